// File: rtl/inst_fetch_stage_pkg.sv
// rtl/inst_fetch_stage_pkg.sv - shared types and constants for the instruction fetch stage
package inst_fetch_stage_pkg;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_FULL = 2'd2
    } if_state_e;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'hBFC0_0000;
    localparam logic [1:0]  INST_SIZE_WORD   = 2'b10;

    function automatic logic [31:0] next_seq_pc(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/inst_skid_buffer.sv
// rtl/inst_skid_buffer.sv - one-entry {pc,inst} holding register for words decode cannot take yet
module inst_skid_buffer (
    input  logic        clk,
    input  logic        resetn,
    input  logic        load,
    input  logic        unload,
    input  logic [31:0] load_pc,
    input  logic [31:0] load_inst,
    output logic        full,
    output logic [31:0] pc,
    output logic [31:0] inst
);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            full <= 1'b0;
            pc   <= 32'd0;
            inst <= 32'd0;
        end else if (load) begin
            full <= 1'b1;
            pc   <= load_pc;
            inst <= load_inst;
        end else if (unload) begin
            full <= 1'b0;
        end
    end

endmodule

// File: rtl/inst_fetch_stage.sv
// rtl/inst_fetch_stage.sv - PC owner, single-outstanding fetch FSM and delay-slot-aware redirect
module inst_fetch_stage
    import inst_fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        resetn,
    output logic        inst_req,
    output logic        inst_wr,
    output logic [1:0]  inst_size,
    output logic [31:0] inst_addr,
    output logic [31:0] inst_wdata,
    input  logic        inst_addr_ok,
    input  logic        inst_data_ok,
    input  logic [31:0] inst_rdata,
    input  logic        id_allowin,
    input  logic        br_valid,
    input  logic [31:0] br_target,
    output logic        if_id_valid,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_inst
);

    if_state_e   state;
    logic [31:0] pc;
    logic [31:0] req_pc;
    logic        redir_pending;
    logic [31:0] redir_target;

    logic        out_free;
    logic        skid_load;
    logic        skid_unload;
    logic        skid_full;
    logic [31:0] skid_pc;
    logic [31:0] skid_inst;

    assign inst_req   = resetn && (state == S_REQ);
    assign inst_wr    = 1'b0;
    assign inst_size  = INST_SIZE_WORD;
    assign inst_addr  = {pc[31:2], 2'b00};
    assign inst_wdata = 32'd0;

    // The output register can take a new word if it is empty or being consumed now.
    assign out_free    = !if_id_valid || id_allowin;
    assign skid_load   = (state == S_WAIT) && inst_data_ok && !out_free;
    assign skid_unload = (state == S_FULL) && skid_full && id_allowin;

    inst_skid_buffer u_skid (
        .clk       (clk),
        .resetn    (resetn),
        .load      (skid_load),
        .unload    (skid_unload),
        .load_pc   (req_pc),
        .load_inst (inst_rdata),
        .full      (skid_full),
        .pc        (skid_pc),
        .inst      (skid_inst)
    );

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state         <= S_REQ;
            pc            <= RESET_PC;
            req_pc        <= RESET_PC;
            redir_pending <= 1'b0;
            redir_target  <= 32'd0;
            if_id_valid   <= 1'b0;
            if_id_pc      <= 32'd0;
            if_id_inst    <= 32'd0;
        end else begin
            if (if_id_valid && id_allowin) begin
                if_id_valid <= 1'b0;
            end
            case (state)
                S_REQ: begin
                    if (inst_addr_ok) begin
                        // The request accepted here is the delay slot whenever a redirect is due.
                        state         <= S_WAIT;
                        req_pc        <= pc;
                        redir_pending <= 1'b0;
                        if (br_valid) begin
                            pc <= br_target;
                        end else if (redir_pending) begin
                            pc <= redir_target;
                        end else begin
                            pc <= next_seq_pc(pc);
                        end
                    end else if (br_valid) begin
                        redir_pending <= 1'b1;
                        redir_target  <= br_target;
                    end
                end
                S_WAIT: begin
                    if (br_valid) begin
                        pc <= br_target;
                    end
                    if (inst_data_ok) begin
                        if (out_free) begin
                            if_id_valid <= 1'b1;
                            if_id_pc    <= req_pc;
                            if_id_inst  <= inst_rdata;
                            state       <= S_REQ;
                        end else begin
                            state <= S_FULL;
                        end
                    end
                end
                S_FULL: begin
                    if (br_valid) begin
                        pc <= br_target;
                    end
                    if (skid_unload) begin
                        if_id_valid <= 1'b1;
                        if_id_pc    <= skid_pc;
                        if_id_inst  <= skid_inst;
                        state       <= S_REQ;
                    end
                end
                default: state <= S_REQ;
            endcase
        end
    end

endmodule

// File: tb/tb_inst_fetch_stage.sv
// tb/tb_inst_fetch_stage.sv - directed and randomized bench for inst_fetch_stage against a program-order model
module tb_inst_fetch_stage;

    localparam logic [31:0] RST = 32'hBFC0_0000;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        inst_req, inst_wr;
    logic [1:0]  inst_size;
    logic [31:0] inst_addr, inst_wdata;
    logic        inst_addr_ok = 1'b0, inst_data_ok = 1'b0;
    logic [31:0] inst_rdata = 32'd0;
    logic        id_allowin = 1'b0, br_valid = 1'b0;
    logic [31:0] br_target = 32'd0;
    logic        if_id_valid;
    logic [31:0] if_id_pc, if_id_inst;

    always #5 clk = ~clk;

    inst_fetch_stage #(.RESET_PC(RST)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .inst_req     (inst_req),
        .inst_wr      (inst_wr),
        .inst_size    (inst_size),
        .inst_addr    (inst_addr),
        .inst_wdata   (inst_wdata),
        .inst_addr_ok (inst_addr_ok),
        .inst_data_ok (inst_data_ok),
        .inst_rdata   (inst_rdata),
        .id_allowin   (id_allowin),
        .br_valid     (br_valid),
        .br_target    (br_target),
        .if_id_valid  (if_id_valid),
        .if_id_pc     (if_id_pc),
        .if_id_inst   (if_id_inst)
    );

    int checks = 0;
    int errors = 0;
    int ncyc = 0;
    int last_cons = 0;

    // Reference: expected next delivered pc in program order, with a delay slot pending flag.
    logic [31:0] exp_pc = RST;
    logic        exp_delay = 1'b0;
    logic [31:0] exp_tgt = 32'd0;

    logic        mem_busy = 1'b0;
    logic [31:0] mem_addr = 32'd0;
    int          mem_cnt = 0;

    int p_addr = 100, max_dly = 0, allow_mode = 1, p_br = 0, hold_cnt = 0, stray = 0;
    logic        force_en = 1'b0;
    logic [31:0] force_pc = 32'd0, force_tgt = 32'd0;
    int          force_hold = 0;

    logic [31:0] cons_log[$];
    int          cons_cyc[$];
    logic [31:0] acc_log[$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        exp_pc    = RST;
        exp_delay = 1'b0;
        mem_busy  = 1'b0;
        last_cons = ncyc;
    endtask

    task automatic cycle();
        logic        busy0;
        logic        take_br;
        logic [31:0] tgt;
        int          r;
        tgt = 32'd0;
        @(negedge clk);
        ncyc++;
        inst_data_ok = 1'b0;
        inst_addr_ok = 1'b0;
        br_valid     = 1'b0;
        br_target    = $urandom;
        inst_rdata   = $urandom;
        id_allowin   = 1'($urandom_range(0, 1));
        if (!resetn) begin
            mem_busy = 1'b0;
            chk("reset_req", 32'(inst_req), 32'd0);
            chk("reset_valid", 32'(if_id_valid), 32'd0);
            chk("reset_pc", if_id_pc, 32'd0);
            return;
        end
        chk("tied_wr", 32'(inst_wr), 32'd0);
        chk("tied_size", 32'(inst_size), 32'd2);
        chk("tied_wdata", inst_wdata, 32'd0);
        busy0 = mem_busy;
        if (stray > 0) begin
            inst_data_ok = 1'b1;
            stray--;
        end else if (mem_busy) begin
            if (mem_cnt == 0) begin
                inst_data_ok = 1'b1;
                inst_rdata   = mem_word(mem_addr);
                mem_busy     = 1'b0;
            end else begin
                mem_cnt--;
            end
        end
        case (allow_mode)
            0:       id_allowin = 1'b0;
            1:       id_allowin = 1'b1;
            2:       id_allowin = !inst_req;
            default: id_allowin = 1'($urandom_range(0, 1));
        endcase
        if (if_id_valid && id_allowin) begin
            chk("deliver_pc", if_id_pc, exp_pc);
            chk("deliver_inst", if_id_inst, mem_word({exp_pc[31:2], 2'b00}));
            cons_log.push_back(if_id_pc);
            cons_cyc.push_back(ncyc);
            last_cons = ncyc;
            take_br = 1'b0;
            if (!exp_delay) begin
                if (force_en && exp_pc == force_pc) begin
                    take_br  = 1'b1;
                    tgt      = force_tgt;
                    hold_cnt = force_hold;
                    force_en = 1'b0;
                end else if ($urandom_range(0, 99) < p_br) begin
                    take_br = 1'b1;
                    r = $urandom_range(0, 15);
                    if (r == 0)      tgt = 32'hFFFF_FFF8;
                    else if (r == 1) tgt = RST + 32'($urandom_range(0, 1023));
                    else             tgt = RST + 32'($urandom_range(0, 255)) * 32'd4;
                end
            end
            if (take_br) begin
                br_valid  = 1'b1;
                br_target = tgt;
                exp_tgt   = tgt;
                exp_delay = 1'b1;
                exp_pc    = exp_pc + 32'd4;
            end else if (exp_delay) begin
                exp_delay = 1'b0;
                exp_pc    = exp_tgt;
            end else begin
                exp_pc = exp_pc + 32'd4;
            end
        end else if (ncyc - last_cons > 100) begin
            chk("progress_timeout", 32'(ncyc - last_cons), 32'd0);
            last_cons = ncyc;
        end
        if (inst_req) begin
            chk("one_outstanding", 32'(busy0), 32'd0);
            chk("addr_align", 32'(inst_addr[1:0]), 32'd0);
            if (hold_cnt > 0) begin
                hold_cnt--;
            end else if ($urandom_range(0, 99) < p_addr) begin
                inst_addr_ok = 1'b1;
                mem_busy     = 1'b1;
                mem_addr     = inst_addr;
                mem_cnt      = $urandom_range(0, max_dly);
                acc_log.push_back(inst_addr);
            end
        end else begin
            inst_addr_ok = 1'($urandom_range(0, 1));
        end
    endtask

    initial begin
        int k;
        int n0;
        logic found;

        // Reset held three cycles, then release.
        resetn = 1'b0;
        repeat (3) cycle();
        resetn = 1'b1;
        inst_addr_ok = 1'b0;
        inst_data_ok = 1'b0;
        #1;
        chk("req_after_reset", 32'(inst_req), 32'd1);
        chk("addr_after_reset", inst_addr, RST);
        model_reset();

        // Streaming at the best-case rate.
        for (int i = 0; i < 50 && cons_log.size() < 3; i++) cycle();
        chk("stream_count", 32'(cons_log.size()), 32'd3);
        chk("stream_pc0", cons_log[0], RST);
        chk("stream_pc1", cons_log[1], RST + 32'h4);
        chk("stream_pc2", cons_log[2], RST + 32'h8);
        chk("stream_gap1", 32'(cons_cyc[1] - cons_cyc[0]), 32'd2);
        chk("stream_gap2", 32'(cons_cyc[2] - cons_cyc[1]), 32'd2);

        // Decode stalls: output holds one word, skid the next, no further requests.
        allow_mode = 0;
        repeat (8) cycle();
        chk("stall_req", 32'(inst_req), 32'd0);
        chk("stall_valid", 32'(if_id_valid), 32'd1);
        chk("stall_pc", if_id_pc, RST + 32'hC);

        // Release the stall and take a branch whose consume lands while a fetch is in flight.
        allow_mode = 2;
        force_en   = 1'b1;
        force_pc   = RST + 32'h10;
        force_tgt  = RST + 32'h100;
        force_hold = 0;
        for (int i = 0; i < 60 && cons_log.size() < 8; i++) cycle();
        chk("br_wait_count", 32'(cons_log.size() >= 8), 32'd1);
        chk("br_wait_held", cons_log[3], RST + 32'hC);
        chk("br_wait_skid", cons_log[4], RST + 32'h10);
        chk("br_wait_slot", cons_log[5], RST + 32'h14);
        chk("br_wait_tgt", cons_log[6], RST + 32'h100);
        chk("br_wait_tgt4", cons_log[7], RST + 32'h104);

        // Branch consumed in the request state with the bus refusing for three cycles.
        allow_mode = 1;
        force_en   = 1'b1;
        force_pc   = RST + 32'h110;
        force_tgt  = RST + 32'h200;
        force_hold = 3;
        for (int i = 0; i < 100 && cons_log.size() < 14; i++) cycle();
        chk("br_req_tgt", cons_log[12], RST + 32'h200);
        k = -1;
        foreach (acc_log[i]) if (acc_log[i] == RST + 32'h114) k = i;
        found = (k >= 0) && (k + 1 < acc_log.size());
        chk("br_req_slot_accepted", 32'(found), 32'd1);
        if (found) chk("br_req_next_addr", acc_log[k + 1], RST + 32'h200);

        // Reset while a request is outstanding, then a stray data_ok after release.
        allow_mode = 3;
        max_dly    = 2;
        for (int i = 0; i < 50 && !(mem_busy && !inst_req); i++) cycle();
        chk("wait_state_reached", 32'(mem_busy && !inst_req), 32'd1);
        resetn = 1'b0;
        repeat (2) cycle();
        resetn = 1'b1;
        model_reset();
        inst_addr_ok = 1'b0;
        inst_data_ok = 1'b1;
        inst_rdata   = 32'hDEAD_BEEF;
        stray        = 1;
        hold_cnt     = 1;
        n0 = cons_log.size();
        for (int i = 0; i < 40 && cons_log.size() <= n0; i++) cycle();
        chk("post_reset_first_pc", cons_log[n0], RST);

        // Randomized traffic with branches, including wrap and unaligned targets.
        p_br = 15;
        for (int ph = 0; ph < 8; ph++) begin
            p_addr     = $urandom_range(30, 100);
            max_dly    = $urandom_range(0, 3);
            allow_mode = $urandom_range(1, 3);
            repeat (400) cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
